instruction_fetch_stage: RTL and testbench

Fetch stage of the 32-bit MIPS pipeline. It sits directly upstream of the instruction memory and drives its Address input. It holds the program counter and captures the returned instruction into the IF/ID pipeline register for decode. It also handles stall, flush and branch/jump redirection, and keeps a retired-fetch counter for debug.

---
 rtl/pipeline_pkg.sv | 27 ++
 rtl/ifid_register.sv | 35 +++
 rtl/instruction_fetch_stage.sv | 93 +++++++++
 tb/tb_instruction_fetch_stage.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared fetch-stage types and constants: reset values, PC width,
// next-PC select encoding and the BOOT/RUN sequencer states.
package pipeline_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [PC_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_HOLD   = 2'd1,
    SEL_BRANCH = 2'd2,
    SEL_JUMP   = 2'd3
  } pc_sel_e;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // Redirect targets are byte addresses; the PC only ever holds word addresses.
  function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register: instruction word, its PC+4 and a valid flag.
// Bubble beats load; with neither asserted every field holds.
module ifid_register
  import pipeline_pkg::*;
#(
  parameter logic [PC_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            bubble,
  input  logic [PC_W-1:0] instr_in,
  input  logic [PC_W-1:0] pc4_in,
  output logic [PC_W-1:0] instr_q,
  output logic [PC_W-1:0] pc4_q,
  output logic            valid_q
);

  // Bubble inserts a NOP but keeps the old PC+4; load captures a new fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (bubble) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
    end else if (load) begin
      instr_q <= instr_in;
      pc4_q   <= pc4_in;
      valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: program counter, next-PC selection, IF/ID register
// and a count of instructions accepted into IF/ID.
//
// state | meaning
// BOOT  | in reset; PC presented as RESET_PC, IF/ID held as a bubble
// RUN   | normal fetch after the first edge with reset released
module instruction_fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [PC_W-1:0] PC_STEP  = 32'd4,
  parameter logic [PC_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Stall,
  input  logic            Flush,
  input  logic            Branch,
  input  logic [PC_W-1:0] BranchTarget,
  input  logic            Jump,
  input  logic [PC_W-1:0] JumpTarget,
  output logic [PC_W-1:0] Address,
  input  logic [PC_W-1:0] Instruction,
  output logic [PC_W-1:0] IFID_Instruction,
  output logic [PC_W-1:0] IFID_PCPlus4,
  output logic            IFID_Valid,
  output logic [PC_W-1:0] FetchCount
);

  fetch_state_e    state_q, state_d;
  pc_sel_e         pc_sel;
  logic [PC_W-1:0] pc_q, pc_d, fetch_pc, pc_plus4;
  logic            ifid_bubble, ifid_load;

  assign fetch_pc = (state_q == BOOT) ? RESET_PC : pc_q;
  assign pc_plus4 = fetch_pc + PC_STEP;
  assign Address  = fetch_pc;

  // Sequencer state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= BOOT;
    else      state_q <= state_d;
  end

  // Next state, next-PC select and IF/ID control; redirects override stall.
  always_comb begin
    state_d     = RUN;
    pc_sel      = SEL_SEQ;
    pc_d        = pc_plus4;
    ifid_bubble = Flush | Jump | Branch;
    ifid_load   = 1'b0;

    if (Jump)        pc_sel = SEL_JUMP;
    else if (Branch) pc_sel = SEL_BRANCH;
    else if (Stall)  pc_sel = SEL_HOLD;

    case (pc_sel)
      SEL_JUMP:   pc_d = align_word(JumpTarget);
      SEL_BRANCH: pc_d = align_word(BranchTarget);
      SEL_HOLD:   pc_d = fetch_pc;
      default:    pc_d = pc_plus4;
    endcase

    ifid_load = !ifid_bubble && !Stall;
  end

  // Program counter.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  // Retired-fetch counter: counts only real loads into IF/ID.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)           FetchCount <= '0;
    else if (ifid_load) FetchCount <= FetchCount + 32'd1;
  end

  ifid_register #(
    .NOP_WORD (NOP_WORD)
  ) u_ifid (
    .clk      (Clk),
    .rst_n    (Rst),
    .load     (ifid_load),
    .bubble   (ifid_bubble),
    .instr_in (Instruction),
    .pc4_in   (pc_plus4),
    .instr_q  (IFID_Instruction),
    .pc4_q    (IFID_PCPlus4),
    .valid_q  (IFID_Valid)
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for the fetch stage: vector table plus a reset sequence.
module tb_instruction_fetch_stage;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Stall = 1'b0, Flush = 1'b0, Branch = 1'b0, Jump = 1'b0;
  logic [31:0] BranchTarget = '0, JumpTarget = '0;
  logic [31:0] Address, Instruction;
  logic [31:0] IFID_Instruction, IFID_PCPlus4, FetchCount;
  logic        IFID_Valid;

  int compared = 0;
  int mismatched = 0;

  always #5 Clk = ~Clk;

  // Instruction memory model: three program words, then an address-tagged pattern.
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h2008_0001;
      32'h4:   return 32'h2009_0002;
      32'h8:   return 32'h0109_5020;
      default: return {a[15:0], 16'hA5A5};
    endcase
  endfunction

  assign Instruction = imem(Address);

  instruction_fetch_stage dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .Stall            (Stall),
    .Flush            (Flush),
    .Branch           (Branch),
    .BranchTarget     (BranchTarget),
    .Jump             (Jump),
    .JumpTarget       (JumpTarget),
    .Address          (Address),
    .Instruction      (Instruction),
    .IFID_Instruction (IFID_Instruction),
    .IFID_PCPlus4     (IFID_PCPlus4),
    .IFID_Valid       (IFID_Valid),
    .FetchCount       (FetchCount)
  );

  typedef struct {
    logic        stall, flush, branch, jump;
    logic [31:0] btgt, jtgt;
    logic [31:0] addr, instr, pc4;
    logic        valid;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic s, f, b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt,
                              input logic [31:0] ad, ins, p4,
                              input logic v, input logic [31:0] c);
    vec_t r;
    r.stall = s; r.flush = f; r.branch = b; r.btgt = bt; r.jump = j; r.jtgt = jt;
    r.addr = ad; r.instr = ins; r.pc4 = p4; r.valid = v; r.cnt = c;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ad, ins, p4,
                         input logic v, input logic [31:0] c);
    chk({tag, ".Address"}, Address, ad);
    chk({tag, ".IFID_Instruction"}, IFID_Instruction, ins);
    chk({tag, ".IFID_PCPlus4"}, IFID_PCPlus4, p4);
    chk({tag, ".IFID_Valid"}, {31'd0, IFID_Valid}, {31'd0, v});
    chk({tag, ".FetchCount"}, FetchCount, c);
  endtask

  task automatic drive(input logic s, f, b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
    Stall = s; Flush = f; Branch = b; BranchTarget = bt; Jump = j; JumpTarget = jt;
  endtask

  initial begin
    //               stall flush br  btgt          jump jtgt          addr          instr         pc4       v  cnt
    vecs[0]  = mk(0, 0, 0, 32'h0,  0, 32'h0,          32'h4,        32'h2008_0001, 32'h4,  1, 1);
    vecs[1]  = mk(0, 0, 0, 32'h0,  0, 32'h0,          32'h8,        32'h2009_0002, 32'h8,  1, 2);
    vecs[2]  = mk(1, 0, 0, 32'h0,  0, 32'h0,          32'h8,        32'h2009_0002, 32'h8,  1, 2);
    vecs[3]  = mk(1, 0, 0, 32'h0,  0, 32'h0,          32'h8,        32'h2009_0002, 32'h8,  1, 2);
    vecs[4]  = mk(0, 0, 0, 32'h0,  0, 32'h0,          32'hC,        32'h0109_5020, 32'hC,  1, 3);
    vecs[5]  = mk(0, 0, 1, 32'h40, 0, 32'h0,          32'h40,       32'h0,         32'hC,  0, 3);
    vecs[6]  = mk(0, 0, 0, 32'h0,  0, 32'h0,          32'h44,       32'h0040_A5A5, 32'h44, 1, 4);
    vecs[7]  = mk(0, 0, 1, 32'h40, 1, 32'h103,        32'h100,      32'h0,         32'h44, 0, 4);
    vecs[8]  = mk(0, 0, 0, 32'h0,  1, 32'h20,         32'h20,       32'h0,         32'h44, 0, 4);
    vecs[9]  = mk(1, 1, 0, 32'h0,  0, 32'h0,          32'h20,       32'h0,         32'h44, 0, 4);
    vecs[10] = mk(1, 0, 0, 32'h0,  0, 32'h0,          32'h20,       32'h0,         32'h44, 0, 4);
    vecs[11] = mk(0, 0, 0, 32'h0,  0, 32'h0,          32'h24,       32'h0020_A5A5, 32'h24, 1, 5);
    vecs[12] = mk(1, 0, 1, 32'h41, 0, 32'h0,          32'h40,       32'h0,         32'h24, 0, 5);
    vecs[13] = mk(0, 1, 0, 32'h0,  0, 32'h0,          32'h44,       32'h0,         32'h24, 0, 5);
    vecs[14] = mk(0, 0, 0, 32'h0,  1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 32'h0,        32'h24, 0, 5);
    vecs[15] = mk(0, 0, 0, 32'h0,  0, 32'h0,          32'h0,        32'hFFFC_A5A5, 32'h0,  1, 6);

    // Reset held across an edge: everything at reset values.
    @(posedge Clk); #1;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].branch, vecs[i].btgt,
            vecs[i].jump, vecs[i].jtgt);
      @(posedge Clk); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].instr, vecs[i].pc4,
              vecs[i].valid, vecs[i].cnt);
      @(negedge Clk);
    end

    // Get to PC=0x44, then pull reset between edges.
    drive(0, 0, 0, 32'h0, 1, 32'h40);
    @(posedge Clk); #1;
    @(negedge Clk);
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    @(posedge Clk); #1;
    chk("pre_reset.Address", Address, 32'h44);
    chk("pre_reset.FetchCount", FetchCount, 32'h7);
    #2;
    Rst = 1'b0;
    #1;
    chk_all("async_reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Redirect and stall under reset must leave nothing behind.
    drive(1, 0, 1, 32'h80, 1, 32'h200);
    @(posedge Clk); #1;
    chk_all("reset_dominates", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge Clk);
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    Rst = 1'b1;
    @(posedge Clk); #1;
    chk_all("first_edge", 32'h4, 32'h2008_0001, 32'h4, 1'b1, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
